// File: rtl/cb_filter_pkg.sv
// cb_filter_pkg: shared types for the counting bloom filter hazard gate
package cb_filter_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} cb_gate_state_e;
endpackage

// File: rtl/cb_gate_fifo.sv
// cb_gate_fifo: in-flight address FIFO with wrap-bit pointers
module cb_gate_fifo #(
  parameter int AddrWidth = 32,
  parameter int Depth = 8,
  localparam int PtrWidth = $clog2(Depth) + 1,
  localparam int CntWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push,
  input  logic                 pop,
  input  logic [AddrWidth-1:0] push_data,
  output logic                 full,
  output logic                 empty,
  output logic [CntWidth-1:0]  count,
  output logic [AddrWidth-1:0] head
);
  logic [AddrWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0] wptr, rptr;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (push) mem[wptr[PtrWidth-2:0]] <= push_data;
  assign count = CntWidth'(wptr - rptr);
  assign empty = wptr == rptr;
  assign full  = (wptr[PtrWidth-1] != rptr[PtrWidth-1]) && (wptr[PtrWidth-2:0] == rptr[PtrWidth-2:0]);
  assign head  = mem[rptr[PtrWidth-2:0]];
endmodule

// File: rtl/cb_hazard_gate.sv
// cb_hazard_gate: stalls aliasing requests ahead of a counting bloom filter and sequences flushes
module cb_hazard_gate
  import cb_filter_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int Depth = 8,
  localparam int CntWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 fwd_valid_o,
  input  logic                 fwd_ready_i,
  output logic [AddrWidth-1:0] fwd_addr_o,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  output logic [AddrWidth-1:0] look_data_o,
  input  logic                 look_valid_i,
  output logic [AddrWidth-1:0] incr_data_o,
  output logic                 incr_valid_o,
  output logic [AddrWidth-1:0] decr_data_o,
  output logic                 decr_valid_o,
  output logic                 filter_clear_o,
  input  logic                 filter_full_i,
  input  logic                 filter_error_i,
  input  logic                 flush_i,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 busy_o,
  output logic                 error_o
);
  cb_gate_state_e state_q, state_d;
  logic fifo_full, fifo_empty, accept, retire;
  logic [AddrWidth-1:0] fifo_head;
  cb_gate_fifo #(.AddrWidth(AddrWidth), .Depth(Depth)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(accept),
    .pop(retire),
    .push_data(req_addr_i),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(outstanding_o),
    .head(fifo_head)
  );
  // reset gating keeps filter ports quiet while rst_i is held
  assign req_ready_o = ~rst_i & (state_q == RUN) & ~flush_i & ~look_valid_i & ~filter_full_i
                       & ~fifo_full & (~fwd_valid_o | fwd_ready_i);
  assign accept = req_valid_i & req_ready_o;
  assign rsp_ready_o = ~fifo_empty;
  assign retire = rsp_valid_i & rsp_ready_o & ~rst_i;
  assign look_data_o = req_addr_i;
  assign incr_data_o = req_addr_i;
  assign incr_valid_o = accept;
  assign decr_data_o = fifo_head;
  assign decr_valid_o = retire;
  assign filter_clear_o = state_q == CLEAR;
  assign busy_o = state_q != RUN;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == RUN && flush_i) ? DRAIN :
              (state_q == DRAIN && fifo_empty && !fwd_valid_o && !retire) ? CLEAR :
              (state_q == CLEAR) ? RUN : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fwd_valid_o <= 1'b0;
      fwd_addr_o <= '0;
      error_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fwd_valid_o <= 1'b1;
        fwd_addr_o <= req_addr_i;
      end else if (fwd_ready_i) begin
        fwd_valid_o <= 1'b0;
      end
      error_o <= (state_q == CLEAR) ? 1'b0 : (error_o | filter_error_i);
    end
  end
endmodule

// File: tb/tb_cb_hazard_gate.sv
// tb_cb_hazard_gate: directed scoreboard bench with a live counting-filter model
module tb_cb_hazard_gate;
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, fwd_valid, fwd_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr, fwd_addr, look_data, incr_data, decr_data;
  logic incr_valid, decr_valid, filter_clear, filter_full, filter_error, flush;
  logic look_valid, busy, error;
  logic [3:0] outstanding;
  int checks = 0, failures = 0;
  int cnt [256];
  logic [31:0] fwd_q[$], decr_q[$];
  always #5 clk = ~clk;
  cb_hazard_gate dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .fwd_valid_o(fwd_valid), .fwd_ready_i(fwd_ready), .fwd_addr_o(fwd_addr),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready),
    .look_data_o(look_data), .look_valid_i(look_valid),
    .incr_data_o(incr_data), .incr_valid_o(incr_valid),
    .decr_data_o(decr_data), .decr_valid_o(decr_valid),
    .filter_clear_o(filter_clear), .filter_full_i(filter_full),
    .filter_error_i(filter_error), .flush_i(flush),
    .outstanding_o(outstanding), .busy_o(busy), .error_o(error)
  );
  assign look_valid = cnt[look_data[7:0]] != 0;
  always @(posedge clk)
    for (int i = 0; i < 256; i++)
      cnt[i] <= (rst || filter_clear) ? 0 :
                cnt[i] + ((incr_valid && incr_data[7:0] == 8'(i)) ? 1 : 0)
                       - ((decr_valid && decr_data[7:0] == 8'(i)) ? 1 : 0);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (fwd_valid && fwd_ready) begin
      chk("fwd_pending", 32'(fwd_q.size() != 0), 1);
      if (fwd_q.size() != 0) chk("fwd_addr", fwd_addr, fwd_q.pop_front());
    end
    if (decr_valid) begin
      chk("decr_pending", 32'(decr_q.size() != 0), 1);
      if (decr_q.size() != 0) chk("decr_data", decr_data, decr_q.pop_front());
    end
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_req(input logic [31:0] a, input logic exp);
    req_valid = 1'b1;
    req_addr = a;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp));
    chk("incr_valid", 32'(incr_valid), 32'(exp));
    if (exp) begin
      chk("incr_data", incr_data, a);
      fwd_q.push_back(a);
      decr_q.push_back(a);
    end
  endtask
  initial begin
    rst = 1; req_valid = 0; req_addr = 0; fwd_ready = 1; rsp_valid = 0;
    filter_full = 0; filter_error = 0; flush = 0;
    cyc; cyc;
    req_valid = 1; req_addr = 32'h999; rsp_valid = 1; #1;
    chk("rst_incr_valid", 32'(incr_valid), 0);
    chk("rst_decr_valid", 32'(decr_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = 0; rsp_valid = 0;
    cyc; rst = 0;
    chk("rst_fwd_valid", 32'(fwd_valid), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_clear", 32'(filter_clear), 0);
    drive_req(32'h100, 1);
    cyc; req_valid = 0;
    chk("t1_fwd_valid", 32'(fwd_valid), 1);
    chk("t1_fwd_addr", fwd_addr, 32'h100);
    chk("t1_outstanding", 32'(outstanding), 1);
    drive_req(32'h100, 0);
    cyc;
    drive_req(32'h100, 0);
    rsp_valid = 1;
    drive_req(32'h100, 0);
    chk("t2_decr_valid", 32'(decr_valid), 1);
    chk("t2_decr_data", decr_data, 32'h100);
    cyc; rsp_valid = 0;
    drive_req(32'h100, 1);
    cyc; req_valid = 0;
    chk("t2_outstanding", 32'(outstanding), 1);
    rsp_valid = 1;
    cyc; rsp_valid = 0;
    chk("t2_drained", 32'(outstanding), 0);
    for (int i = 0; i < 8; i++) begin
      drive_req(32'h210 + 32'(i), 1);
      cyc;
    end
    drive_req(32'h300, 0);
    chk("t3_full_outstanding", 32'(outstanding), 8);
    rsp_valid = 1;
    drive_req(32'h300, 0);
    chk("t3_decr_valid", 32'(decr_valid), 1);
    cyc; rsp_valid = 0;
    drive_req(32'h300, 1);
    cyc; req_valid = 0;
    chk("t3_refill", 32'(outstanding), 8);
    rsp_valid = 1;
    cyc;
    chk("t4_pre", 32'(outstanding), 7);
    drive_req(32'h320, 1);
    chk("t4_decr_valid", 32'(decr_valid), 1);
    chk("t4_decr_oldest", decr_data, 32'h212);
    cyc; req_valid = 0;
    chk("t4_unchanged", 32'(outstanding), 7);
    for (int i = 0; i < 7; i++) cyc;
    rsp_valid = 0;
    chk("t4_drained", 32'(outstanding), 0);
    filter_error = 1;
    cyc; filter_error = 0;
    chk("t5_error_set", 32'(error), 1);
    cyc;
    chk("t5_error_hold", 32'(error), 1);
    for (int i = 0; i < 3; i++) begin
      drive_req(32'h400 + 32'(i), 1);
      cyc;
    end
    req_valid = 0;
    chk("t5_outstanding", 32'(outstanding), 3);
    flush = 1;
    drive_req(32'h500, 0);
    cyc; flush = 0;
    chk("t5_busy", 32'(busy), 1);
    drive_req(32'h500, 0);
    rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("t5_drain_busy", 32'(busy), 1);
      chk("t5_drain_noclear", 32'(filter_clear), 0);
    end
    rsp_valid = 0;
    chk("t5_empty", 32'(outstanding), 0);
    chk("t5_error_drain", 32'(error), 1);
    drive_req(32'h500, 0);
    cyc;
    chk("t5_clear_pulse", 32'(filter_clear), 1);
    chk("t5_clear_busy", 32'(busy), 1);
    drive_req(32'h500, 0);
    cyc;
    chk("t5_clear_done", 32'(filter_clear), 0);
    chk("t5_run", 32'(busy), 0);
    chk("t5_error_cleared", 32'(error), 0);
    drive_req(32'h500, 1);
    cyc; req_valid = 0;
    rsp_valid = 1;
    cyc; rsp_valid = 0;
    chk("t5_after", 32'(outstanding), 0);
    flush = 1;
    cyc; flush = 0;
    chk("f_drain", 32'(busy), 1);
    chk("f_drain_noclear", 32'(filter_clear), 0);
    cyc;
    chk("f_clear", 32'(filter_clear), 1);
    cyc;
    chk("f_run", 32'(busy), 0);
    chk("f_run_noclear", 32'(filter_clear), 0);
    fwd_ready = 0;
    drive_req(32'h600, 1);
    cyc;
    chk("t6_fwd_valid", 32'(fwd_valid), 1);
    chk("t6_fwd_addr", fwd_addr, 32'h600);
    drive_req(32'h701, 0);
    cyc;
    chk("t6_fwd_stable", fwd_addr, 32'h600);
    chk("t6_fwd_held", 32'(fwd_valid), 1);
    drive_req(32'h701, 0);
    fwd_ready = 1;
    drive_req(32'h701, 1);
    cyc; req_valid = 0;
    chk("t6_fwd_next", fwd_addr, 32'h701);
    rsp_valid = 1;
    cyc; cyc; rsp_valid = 0;
    chk("t6_drained", 32'(outstanding), 0);
    filter_full = 1;
    drive_req(32'h800, 0);
    filter_full = 0; req_valid = 0;
    cyc; cyc; cyc;
    chk("end_fwd_q", 32'(fwd_q.size()), 0);
    chk("end_decr_q", 32'(decr_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
